uart_tx_csr: RTL and testbench
==============================

UART_TX_CSR -- requirements
Module: uart_tx_csr

Interface
REQ-001 Parameter CLK_DIV, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..64).
REQ-003 clk_i  input  1  single block clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 wr_en_i  input  1  core CSR write strobe for the TX data register.
REQ-006 wr_data_i  input  8  byte to transmit.
REQ-007 wr_ready_o  output  1  high when the FIFO is not full; combinational from occupancy.
REQ-008 busy_o  output  1  high when the FIFO is non-empty or a frame is in progress.
REQ-009 ovf_o  output  1  sticky overflow flag.
REQ-010 txd_o  output  1  serial line, registered, idle high.
REQ-011 mon_data_o  output  32  simulation mirror: bit 31 is the completion strobe, [7:0] is the byte, [30:8] are always 0.

Function
REQ-012 A write SHALL be accepted when wr_en_i and wr_ready_o are both high at a rising edge; the byte is pushed into the FIFO at that edge.
REQ-013 A write with wr_ready_o low SHALL be dropped and SHALL set ovf_o. This holds even if a pop occurs in the same cycle.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE with FIFO non-empty SHALL pop the head byte into the shift register and enter START, driving txd_o=0.
REQ-016 START SHALL hold txd_o=0 for CLK_DIV cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each held CLK_DIV cycles.
REQ-018 STOP SHALL hold txd_o=1 for CLK_DIV cycles.
REQ-019 A frame SHALL last exactly 10*CLK_DIV cycles.
REQ-020 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START directly with no idle bit; otherwise it SHALL enter IDLE.
REQ-021 Latency: a write accepted at edge E into an empty FIFO while IDLE SHALL make txd_o low from edge E+1.
REQ-022 mon_data_o[31] SHALL be high for exactly one cycle, registered on the cycle the FSM leaves STOP; mon_data_o[7:0] SHALL then equal the transmitted byte.
REQ-023 Outside the strobe cycle, mon_data_o[31] SHALL be 0 and mon_data_o[7:0] SHALL hold the last completed byte.
REQ-024 Bytes SHALL be transmitted and mirrored in write order with no reordering; this includes 0x0a, 0x0d, 0x1b, 0x04 and 0xff, all passed unmodified.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits.
REQ-026 A simultaneous push and pop with the FIFO neither empty nor full SHALL leave occupancy unchanged.
REQ-027 The bit-period counter SHALL be 16 bits wide and reload at every bit boundary.

Reset
REQ-028 Asserting rst_n_i SHALL immediately set txd_o=1, mon_data_o=0, ovf_o=0, FIFO empty, state IDLE, and all counters 0.
REQ-029 Reset mid-frame SHALL abort the frame: txd_o returns high at once, no mirror strobe is issued, and queued bytes are discarded.

Structure
REQ-030 FSM state encodings, the mirror strobe bit index (31), and the control codes ESC=0x1b, EOT=0x04 and LF=0x0a SHALL live in the shared param.v include.
REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, same clock and reset); the FSM and shifter stay in uart_tx_csr.

Verification (CLK_DIV=4, FIFO_DEPTH=8)
REQ-032 Idle, then write 0x41:
  - txd_o low from the next edge;
  - data bits 1,0,0,0,0,0,1,0, each 4 cycles;
  - stop bit high;
  - mon_data_o=0x80000041 for one cycle, 40 cycles after txd_o falls.
REQ-033 Write 0x48, 0x69, 0x0a on consecutive cycles -> txd_o carries continuous frames with no idle gap; mirror strobes 40 cycles apart carrying 0x48, 0x69, 0x0a.
REQ-034 Write 10 bytes on 10 consecutive cycles from idle -> the first 9 are accepted (the first is popped after 1 cycle); the 10th is dropped; ovf_o=1; wr_ready_o is low on cycle 10.
REQ-035 Assert reset during bit 3 of a DATA phase -> txd_o=1, busy_o=0 and mon_data_o=0 immediately, and no strobe occurs after release.
REQ-036 Write 0x1b then 0x04 -> two strobes in order (0x8000001b, then 0x80000004) with mon_data_o[31] low between them, so the attached monitor ends the simulation.

Source files
------------

// File: rtl/uart_tx_csr_pkg.sv
// Shared definitions for the UART transmitter: FSM states, mirror layout, control codes.
// No logic of its own; constants and a packing helper only.
// Imported by uart_tx_csr and by anything that decodes mon_data_o.
package uart_tx_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Completion strobe position inside the 32-bit mirror word.
  localparam int MON_STB_BIT = 31;

  // Control codes that must pass through the transmitter untouched.
  localparam logic [7:0] CHR_ESC = 8'h1b;
  localparam logic [7:0] CHR_EOT = 8'h04;
  localparam logic [7:0] CHR_LF  = 8'h0a;

  // Build the mirror word: strobe at MON_STB_BIT, byte in [7:0], all else zero.
  function automatic logic [31:0] mon_word(input logic stb, input logic [7:0] b);
    logic [31:0] w;
    w = '0;
    w[MON_STB_BIT] = stb;
    w[7:0] = b;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_csr_sync_fifo.sv
// Single-clock FIFO with power-of-two depth and a registered occupancy count.
// Latency: a push is visible at the head on the cycle after the pushing edge.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o     = (cnt_q == CNT_FULL);
  assign empty_o    = (cnt_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; no reset needed since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_csr.sv
// CSR-fed UART transmitter: FIFO-buffered bytes sent 8N1, LSB first, CLK_DIV cycles per bit.
// Latency: a write into an empty idle block drives the start bit from the next edge.
// Backpressure: wr_ready_o drops when the FIFO is full; writes then are dropped and set ovf_o.
module uart_tx_csr
  import uart_tx_csr_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o,
  output logic        busy_o,
  output logic        ovf_o,
  output logic        txd_o,
  output logic [31:0] mon_data_o
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  mon_byte_q, mon_byte_d;
  logic        txd_q, txd_d;
  logic        stb_q, stb_d;
  logic        ovf_q, ovf_d;

  logic        fifo_full, fifo_empty, fifo_pop, load;
  logic [7:0]  fifo_dout;
  logic        bit_end;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (wr_en_i),
    .push_data_i (wr_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wr_ready_o = ~fifo_full;
  assign busy_o     = ~fifo_empty | (state_q != ST_IDLE);
  assign ovf_o      = ovf_q;
  assign txd_o      = txd_q;
  assign mon_data_o = mon_word(stb_q, mon_byte_q);
  assign bit_end    = (cnt_q == '0);
  // A write refused for lack of space is lost even if a pop frees room this cycle.
  assign ovf_d      = ovf_q | (wr_en_i & fifo_full);

  // Frame sequencing: bit timing, shifting, and back-to-back frame loading.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    mon_byte_d = mon_byte_q;
    txd_d      = txd_q;
    stb_d      = 1'b0;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        load  = ~fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = BIT_RELOAD;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stb_d      = 1'b1;
          mon_byte_d = byte_q;
          state_d    = ST_IDLE;
          cnt_d      = '0;
          load       = ~fifo_empty;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Starting a frame: pop the head byte and drive the start bit right away.
    if (load) begin
      fifo_pop = 1'b1;
      state_d  = ST_START;
      cnt_d    = BIT_RELOAD;
      byte_d   = fifo_dout;
      shift_d  = fifo_dout;
      txd_d    = 1'b0;
    end
  end

  // State register; reset aborts any frame with the line forced idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      mon_byte_q <= '0;
      txd_q      <= 1'b1;
      stb_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      mon_byte_q <= mon_byte_d;
      txd_q      <= txd_d;
      stb_q      <= stb_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_csr.sv
// Randomised bench for uart_tx_csr against a queue-and-timeline model of the transmitter.
// Outputs are compared every cycle, 1 time unit after the rising edge.
// Directed scenarios cover single frame, back-to-back frames, overflow, mid-frame reset.
module tb_uart_tx_csr;
  import uart_tx_csr_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 10 * CLK_DIV;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wr_en_i;
  logic [7:0]  wr_data_i;
  logic        wr_ready_o;
  logic        busy_o;
  logic        ovf_o;
  logic        txd_o;
  logic [31:0] mon_data_o;

  uart_tx_csr #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .txd_o      (txd_o),
    .mon_data_o (mon_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted bytes waiting, and the frame currently on the wire.
  logic [7:0] m_q[$];
  int         m_rem;        // cycles left in the current frame, 0 when idle
  logic [7:0] m_cur;        // byte of the current frame
  logic       m_stb;
  logic [7:0] m_last;
  logic       m_ovf;
  int         n_strobes;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rem  = 0;
    m_cur  = 8'h00;
    m_stb  = 1'b0;
    m_last = 8'h00;
    m_ovf  = 1'b0;
  endtask

  // One rising edge of the model: frame time advances, a finished frame is
  // mirrored, the next queued byte starts at once, then the write is judged
  // against the space that existed before this edge.
  task automatic model_edge(input logic en, input logic [7:0] d);
    bit ready;
    ready = (m_q.size() < FIFO_DEPTH);
    m_stb = 1'b0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_stb  = 1'b1;
        m_last = m_cur;
        n_strobes++;
      end
    end
    if (m_rem == 0 && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_rem = FRAME;
    end
    if (en) begin
      if (ready) m_q.push_back(d);
      else       m_ovf = 1'b1;
    end
  endtask

  // Line level from position within the 10-bit frame.
  function automatic logic model_txd();
    int pos, b;
    if (m_rem == 0) return 1'b1;
    pos = FRAME - m_rem;
    b   = pos / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic compare_all(input string ph);
    check_val({ph, ":txd"},   32'(txd_o),      32'(model_txd()));
    check_val({ph, ":busy"},  32'(busy_o),     32'((m_q.size() > 0) || (m_rem > 0)));
    check_val({ph, ":ovf"},   32'(ovf_o),      32'(m_ovf));
    check_val({ph, ":ready"}, 32'(wr_ready_o), 32'(m_q.size() < FIFO_DEPTH));
    check_val({ph, ":mon"},   mon_data_o,      {m_stb, 23'd0, m_last});
  endtask

  task automatic step(input string ph, input logic en, input logic [7:0] d);
    @(negedge clk_i);
    wr_en_i   = en;
    wr_data_i = d;
    @(posedge clk_i);
    model_edge(en, d);
    #1;
    compare_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    wr_en_i = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  logic [7:0] specials [5];
  logic [7:0] msg [3];
  int         fall_t, strobe_t;

  initial begin
    specials[0] = CHR_LF; specials[1] = 8'h0d; specials[2] = CHR_ESC;
    specials[3] = CHR_EOT; specials[4] = 8'hff;
    n_strobes = 0;
    rst_n_i   = 1'b0;
    wr_en_i   = 1'b0;
    wr_data_i = 8'h00;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle("idle", 3);

    // Single frame 0x41; also time the start-bit-to-strobe distance directly.
    step("a41", 1'b1, 8'h41);
    step("a41", 1'b0, 8'h00);
    check_val("a41_fall", 32'(txd_o), 32'd0);
    fall_t = n_checks;
    strobe_t = -1;
    for (int i = 1; i <= FRAME + 5; i++) begin
      step("a41", 1'b0, 8'h00);
      if (mon_data_o[MON_STB_BIT] && strobe_t < 0) strobe_t = i;
    end
    check_val("a41_dist", 32'(strobe_t), 32'(FRAME));
    fall_t = 0;

    // Three back-to-back frames from consecutive writes.
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = CHR_LF;
    for (int i = 0; i < 3; i++) step("hi", 1'b1, msg[i]);
    idle("hi", 3 * FRAME + 10);

    // Ten consecutive writes from idle: ninth fills the FIFO, tenth overflows.
    for (int i = 0; i < 10; i++) step("burst", 1'b1, 8'(8'h30 + i));
    check_val("burst_ovf", 32'(ovf_o), 32'd1);
    idle("burst", 9 * FRAME + 10);

    // Reset during data bit 3 of a frame.
    pulse_reset();
    step("midrst", 1'b1, 8'h55);
    idle("midrst", 18);
    #2;
    rst_n_i = 1'b0;
    wr_en_i = 1'b0;
    model_reset();
    #1;
    compare_all("midrst_now");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle("post_rst", FRAME + 20);

    // ESC then EOT.
    step("esc", 1'b1, CHR_ESC);
    step("eot", 1'b1, CHR_EOT);
    idle("esceot", 2 * FRAME + 10);

    // Random traffic: alternating sparse and dense phases, mixed byte classes.
    pulse_reset();
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 60; i++) begin
        logic       en;
        logic [7:0] d;
        en = (ph % 2 == 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
        d  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 8'($urandom);
        step("rand", en, d);
      end
    end
    idle("drain", FIFO_DEPTH * FRAME + FRAME + 10);
    check_val("drain_busy", 32'(busy_o), 32'd0);
    check_val("strobes_seen", 32'(n_strobes > 10), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
